// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder (with nibble_cla4)
//  Purpose  : WIDTH-bit adder that walks one nibble per cycle through a 4-bit
//             carry-lookahead adder, with valid/ready handshakes on both sides.
//  Revision : 1.0  initial release
// ============================================================================

module nibble_cla4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a_i & b_i;
    assign w_p = a_i ^ b_i;

    // Every carry is a flat sum of products: no ripple inside the nibble.
    assign w_c[0] = c_i;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3]
                  | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign s_o = w_p ^ w_c[3:0];
    assign c_o = w_c[4];

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [IDX_W+1:0] w_base;
    logic [3:0]       w_nib_a;
    logic [3:0]       w_nib_b;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;

    assign w_base  = {idx_q, 2'b00};
    assign w_nib_a = a_q[w_base +: 4];
    assign w_nib_b = b_q[w_base +: 4];

    nibble_cla4 u_cla (
        .a_i (w_nib_a),
        .b_i (w_nib_b),
        .c_i (carry_q),
        .s_o (w_nib_sum),
        .c_o (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum_q[w_base +: 4] <= w_nib_sum;
                    carry_q            <= w_nib_cout;
                    if (idx_q == LAST_IDX) begin
                        // Overflow: like-signed operands producing an opposite-signed result.
                        cout_q      <= w_nib_cout;
                        ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                                    && (w_nib_sum[3] != a_q[WIDTH-1]);
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire
